// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the unsigned multiply/accumulate slice.
//   S_IDLE / S_ACC / S_DONE : accumulator FSM state encodings
//   clog2                   : ceiling log2, used to size counters
// ----------------------------------------------------------------------------
package mul_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Ceiling log2; clog2(1) = 0 so callers add one bit for a full count range.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_acc_unsigned_sat_add.sv
// ----------------------------------------------------------------------------
// sat_add_unsigned
// Combinational unsigned saturating adder.
//   a   [AW-1:0] : accumulator operand
//   b   [BW-1:0] : addend, zero-extended to AW bits (BW <= AW)
//   sum [AW-1:0] : a + b, clamped to 2^AW-1
//   sat          : high when the true sum exceeded 2^AW-1
// ----------------------------------------------------------------------------
module sat_add_unsigned #(
   parameter int AW = 12,
   parameter int BW = 8
) (
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   output logic [AW-1:0] sum,
   output logic          sat
);

   logic [AW:0] full_s;

   // One extra bit catches the carry that signals saturation.
   always_comb begin
      full_s = {1'b0, a} + {{(AW + 1 - BW){1'b0}}, b};
      sat    = full_s[AW];
      if (full_s[AW]) begin
         sum = {AW{1'b1}};
      end else begin
         sum = full_s[AW-1:0];
      end
   end

endmodule

// File: rtl/mul_acc_unsigned.sv
// ----------------------------------------------------------------------------
// mul_acc_unsigned
// Accumulates LEN unsigned products per run with saturation, returning one
// result per run.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : begins a run (only honoured in IDLE)
//   in_valid/in_ready/z  : product input handshake
//   out_valid/out_ready  : result handshake
//   acc_out, ovf         : saturated sum and sticky saturation flag
//   busy                 : high while a run is in ACC or DONE
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module mul_acc_unsigned
   import mul_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN   = 8,
   parameter int ACC_W = 2*WIDTH + 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] z,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   acc_out,
   output logic               ovf,
   output logic               busy
);

   localparam int             CNT_W    = clog2(LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_r;
   logic             ovf_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [ACC_W-1:0] sum_s;
   logic             sat_s;

   sat_add_unsigned #(
      .AW(ACC_W),
      .BW(2*WIDTH)
   ) u_sat_add (
      .a  (acc_r),
      .b  (z),
      .sum(sum_s),
      .sat(sat_s)
   );

   // Next-state and datapath update for the IDLE -> ACC -> DONE run sequence.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      cnt_nxt_s   = cnt_r;
      ovf_nxt_s   = ovf_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               acc_nxt_s   = {ACC_W{1'b0}};
               cnt_nxt_s   = {CNT_W{1'b0}};
               ovf_nxt_s   = 1'b0;
               state_nxt_s = S_ACC;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_ACC: begin
            // in_ready_r is high throughout ACC, so in_valid alone marks a beat.
            if (in_valid && in_ready_r) begin
               acc_nxt_s = sum_s;
               ovf_nxt_s = ovf_r | sat_s;
               cnt_nxt_s = cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_ACC;
               end
            end else begin
               state_nxt_s = S_ACC;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs decode the next state so
   // they line up with the state register without any input-to-output path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         acc_r       <= acc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         ovf_r       <= ovf_nxt_s;
         in_ready_r  <= (state_nxt_s == S_ACC);
         out_valid_r <= (state_nxt_s == S_DONE);
         busy_r      <= (state_nxt_s != S_IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign acc_out   = acc_r;
   assign ovf       = ovf_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mul_acc_unsigned.sv
// ----------------------------------------------------------------------------
// tb_mul_acc_unsigned
// Four instances with different LEN/ACC_W. Expected sums come from a plain
// arithmetic model: the saturated running sum equals min(prefix total, max).
//   inst 0: LEN=4 ACC_W=12   inst 1: LEN=4 ACC_W=9
//   inst 2: LEN=2 ACC_W=12   inst 3: LEN=1 ACC_W=12
// ----------------------------------------------------------------------------
module tb_mul_acc_unsigned;

   logic              clk;
   logic              rst;
   logic [3:0]        start_v;
   logic [3:0]        in_valid_v;
   logic [3:0]        out_ready_v;
   logic [3:0][7:0]   z_v;
   wire  [3:0]        in_ready_w;
   wire  [3:0]        out_valid_w;
   wire  [3:0]        ovf_w;
   wire  [3:0]        busy_w;
   wire  [3:0][11:0]  acc_w;
   wire  [8:0]        acc9_w;

   int checks;
   int failures;
   int max_a[4] = '{4095, 511, 4095, 4095};
   int len_a[4] = '{4, 4, 2, 1};
   int zq[$];

   assign acc_w[1] = {3'b000, acc9_w};

   mul_acc_unsigned #(.WIDTH(4), .LEN(4), .ACC_W(12)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]),
      .in_ready(in_ready_w[0]), .z(z_v[0]), .out_valid(out_valid_w[0]),
      .out_ready(out_ready_v[0]), .acc_out(acc_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]));

   mul_acc_unsigned #(.WIDTH(4), .LEN(4), .ACC_W(9)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]),
      .in_ready(in_ready_w[1]), .z(z_v[1]), .out_valid(out_valid_w[1]),
      .out_ready(out_ready_v[1]), .acc_out(acc9_w), .ovf(ovf_w[1]), .busy(busy_w[1]));

   mul_acc_unsigned #(.WIDTH(4), .LEN(2), .ACC_W(12)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid_v[2]),
      .in_ready(in_ready_w[2]), .z(z_v[2]), .out_valid(out_valid_w[2]),
      .out_ready(out_ready_v[2]), .acc_out(acc_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]));

   mul_acc_unsigned #(.WIDTH(4), .LEN(1), .ACC_W(12)) u3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid_v[3]),
      .in_ready(in_ready_w[3]), .z(z_v[3]), .out_valid(out_valid_w[3]),
      .out_ready(out_ready_v[3]), .acc_out(acc_w[3]), .ovf(ovf_w[3]), .busy(busy_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks = checks + 1;
      assert (got === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run on instance k using the products in zq, with `gap`
   // idle cycles between beats and `hold` cycles of back-pressure in DONE.
   task automatic run(input int k, input int gap, input int hold);
      int total;
      int n;
      int exp_acc;
      n     = zq.size();
      total = 0;
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      chk($sformatf("in_ready_after_start_i%0d", k), int'(in_ready_w[k]), 1);
      chk($sformatf("busy_after_start_i%0d", k), int'(busy_w[k]), 1);
      for (int i = 0; i < n; i++) begin
         in_valid_v[k] = 1'b1;
         z_v[k]        = 8'(zq[i]);
         total         = total + zq[i];
         tick();
         in_valid_v[k] = 1'b0;
         z_v[k]        = 8'($urandom_range(0, 255));
         exp_acc = (total > max_a[k]) ? max_a[k] : total;
         chk($sformatf("acc_beat%0d_i%0d", i, k), int'(acc_w[k]), exp_acc);
         chk($sformatf("ovf_beat%0d_i%0d", i, k), int'(ovf_w[k]), (total > max_a[k]) ? 1 : 0);
         if (i == n - 1) begin
            chk($sformatf("out_valid_last_i%0d", k), int'(out_valid_w[k]), 1);
            chk($sformatf("in_ready_done_i%0d", k), int'(in_ready_w[k]), 0);
         end else begin
            chk($sformatf("out_valid_early_i%0d", k), int'(out_valid_w[k]), 0);
            for (int g = 0; g < gap; g++) begin
               tick();
               chk($sformatf("out_valid_gap_i%0d", k), int'(out_valid_w[k]), 0);
            end
         end
      end
      exp_acc = (total > max_a[k]) ? max_a[k] : total;
      for (int h = 0; h < hold; h++) begin
         start_v[k]    = 1'b1;
         in_valid_v[k] = 1'b1;
         z_v[k]        = 8'hff;
         tick();
         chk($sformatf("hold_out_valid_i%0d", k), int'(out_valid_w[k]), 1);
         chk($sformatf("hold_in_ready_i%0d", k), int'(in_ready_w[k]), 0);
         chk($sformatf("hold_acc_i%0d", k), int'(acc_w[k]), exp_acc);
      end
      start_v[k]    = 1'b0;
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b1;
      tick();
      out_ready_v[k] = 1'b0;
      chk($sformatf("out_valid_after_hs_i%0d", k), int'(out_valid_w[k]), 0);
      chk($sformatf("busy_after_hs_i%0d", k), int'(busy_w[k]), 0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      start_v     = 4'b0000;
      in_valid_v  = 4'b0000;
      out_ready_v = 4'b0000;
      z_v         = '0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_in_ready_i%0d", k), int'(in_ready_w[k]), 0);
         chk($sformatf("rst_out_valid_i%0d", k), int'(out_valid_w[k]), 0);
         chk($sformatf("rst_busy_i%0d", k), int'(busy_w[k]), 0);
         chk($sformatf("rst_acc_i%0d", k), int'(acc_w[k]), 0);
         chk($sformatf("rst_ovf_i%0d", k), int'(ovf_w[k]), 0);
      end
      tick();
      rst = 1'b0;
      tick();

      // Basic run, no gaps.
      zq = '{225, 140, 0, 26};
      run(0, 0, 0);
      // Same products with idle gaps between beats.
      run(0, 3, 0);
      // Saturation from the third beat.
      zq = '{225, 225, 225, 225};
      run(1, 0, 0);
      // Back-pressure in DONE with stray start/in_valid.
      zq = '{200, 55};
      run(2, 0, 5);
      tick();
      chk("idle_after_hold_busy", int'(busy_w[2]), 0);
      chk("idle_after_hold_in_ready", int'(in_ready_w[2]), 0);

      // Asynchronous reset mid-run after two beats.
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid_v[0] = 1'b1;
         z_v[0]        = 8'd100;
         tick();
      end
      in_valid_v[0] = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_acc", int'(acc_w[0]), 0);
      chk("async_rst_busy", int'(busy_w[0]), 0);
      chk("async_rst_in_ready", int'(in_ready_w[0]), 0);
      chk("async_rst_out_valid", int'(out_valid_w[0]), 0);
      chk("async_rst_ovf", int'(ovf_w[0]), 0);
      tick();
      rst = 1'b0;
      zq = '{1, 1, 1, 1};
      run(0, 0, 0);

      // LEN=1, then a start immediately after the handshake.
      zq = '{15};
      run(3, 0, 0);
      zq = '{7};
      run(3, 0, 0);

      // Randomized runs against the arithmetic model.
      for (int r = 0; r < 12; r++) begin
         int k;
         k = r % 2;
         zq.delete();
         for (int i = 0; i < len_a[k]; i++) begin
            zq.push_back(int'($urandom_range(0, 225)));
         end
         run(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
